telemetry_packetizer: RTL and testbench

Frames one snapshot of sensor fields (attitude, acceleration, altimeter, GPS words) into a byte packet and streams it, one byte at a time, into the data-link serial transmitter. Sits between the sensor controllers and the serial_tx stage. It selects each field through a select/data read port, splits it into bytes, prefixes sync and sequence bytes, optionally appends a checksum, and obeys the transmitter's busy/block handshake.

---
 rtl/telemetry_pkg.sv | 32 +++
 rtl/telemetry_byte_issuer.sv | 54 +++++
 rtl/telemetry_packetizer.sv | 200 ++++++++++++++++++++
 tb/tb_telemetry_packetizer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// -----------------------------------------------------------------------------
// telemetry_pkg
// Shared definitions for the telemetry packetizer: framing constants, the
// packetizer state type and the packet-length helper.
// Optional feature macro: TELEMETRY_CHECKSUM_EN (appends a checksum byte).
// -----------------------------------------------------------------------------
package telemetry_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         BYTES_PER_FIELD = 3;

`ifdef TELEMETRY_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_GUARD,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    // Sync + sequence + field bytes (+ checksum).
    function automatic int packet_len(input int num_fields, input bit csum_en);
        return 2 + BYTES_PER_FIELD * num_fields + (csum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/telemetry_byte_issuer.sv
// -----------------------------------------------------------------------------
// telemetry_byte_issuer
// Hands one byte at a time to the serial transmitter. A byte offered with
// i_valid is accepted only when the transmitter is idle, flow control is open
// and no strobe is already in flight; acceptance registers the byte and
// raises a one-cycle new_tx_data strobe.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_valid, i_byte  byte offered by the packetizer
//   i_tx_busy        transmitter busy
//   i_tx_block       downstream flow control
//   o_accepted       byte taken this cycle (combinational)
//   o_tx_data        registered byte to the transmitter
//   o_new_tx_data    registered one-cycle strobe
// -----------------------------------------------------------------------------
module telemetry_byte_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    input  logic       i_tx_block,
    output logic       o_accepted,
    output logic [7:0] o_tx_data,
    output logic       o_new_tx_data
);

    logic [7:0] r_tx_data;
    logic       r_new_tx_data;
    logic       w_accepted;

    // Refusing while the previous strobe is still high keeps strobes from
    // ever landing on consecutive cycles.
    assign w_accepted = i_valid && !i_tx_busy && !i_tx_block && !r_new_tx_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data     <= 8'h00;
            r_new_tx_data <= 1'b0;
        end else begin
            r_new_tx_data <= w_accepted;
            if (w_accepted) begin
                r_tx_data <= i_byte;
            end
        end
    end

    assign o_accepted    = w_accepted;
    assign o_tx_data     = r_tx_data;
    assign o_new_tx_data = r_new_tx_data;

endmodule

// File: rtl/telemetry_packetizer.sv
// -----------------------------------------------------------------------------
// telemetry_packetizer
// Frames one snapshot of NUM_FIELDS sensor fields into a byte packet
// (0xA5, seq, fields MSB first as 3 bytes each, optional checksum) and
// streams it into the serial transmitter through telemetry_byte_issuer.
// Optional feature macro: TELEMETRY_CHECKSUM_EN. When defined, a byte equal
// to the two's complement of the running sum is appended so that all packet
// bytes sum to 0x00; when undefined the accumulator is not built.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         one-cycle packet request (ignored while busy)
//   o_busy          packet in progress
//   o_done          one-cycle pulse after the last byte is accepted
//   o_overrun       one-cycle pulse when i_start arrives while busy
//   o_seq           sequence number of the next packet
//   o_field_sel     field read select
//   i_field_data    field value, combinational from o_field_sel
//   o_tx_data       byte to transmit
//   o_new_tx_data   one-cycle strobe, o_tx_data valid
//   i_tx_busy       transmitter busy
//   i_tx_block      downstream flow control
// -----------------------------------------------------------------------------
module telemetry_packetizer
    import telemetry_pkg::*;
#(
    parameter int NUM_FIELDS = 8,
    parameter int FIELD_W    = 20,
    parameter int SEL_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun,
    output logic [7:0]         o_seq,
    output logic [SEL_W-1:0]   o_field_sel,
    input  logic [FIELD_W-1:0] i_field_data,
    output logic [7:0]         o_tx_data,
    output logic               o_new_tx_data,
    input  logic               i_tx_busy,
    input  logic               i_tx_block
);

    localparam int CNT_W = $clog2(packet_len(NUM_FIELDS, CSUM_EN) + 1);

    // Byte positions within the packet, as counted by r_byte_idx.
    localparam logic [CNT_W-1:0] IDX_SYNC      = CNT_W'(0);
    localparam logic [CNT_W-1:0] IDX_SEQ       = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDX_FIELD0    = CNT_W'(2);
    localparam logic [CNT_W-1:0] IDX_FIELD_END = CNT_W'(2 + BYTES_PER_FIELD * NUM_FIELDS);
    localparam logic [CNT_W-1:0] IDX_LAST      = CNT_W'(packet_len(NUM_FIELDS, CSUM_EN));
    localparam logic [1:0]       SUB_LAST      = 2'(BYTES_PER_FIELD - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_seq;
    logic [CNT_W-1:0]   r_byte_idx;   // bytes accepted so far in this packet
    logic [1:0]         r_sub;        // byte position within the current field
    logic [SEL_W-1:0]   r_field_sel;
    logic [23:0]        r_shift;
    logic               r_overrun;

    logic               w_in_fields;
    logic               w_valid;
    logic               w_accepted;
    logic [7:0]         w_byte;
    logic [7:0]         w_csum_byte;

    assign w_in_fields = (r_byte_idx >= IDX_FIELD0) && (r_byte_idx < IDX_FIELD_END);
    assign w_valid     = (r_state == ST_EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path through this block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_EMIT;
            ST_LOAD:    w_state_next = ST_EMIT;
            ST_EMIT:    if (w_accepted) w_state_next = ST_GUARD;
            // The transmitter raises busy only one cycle after the strobe.
            ST_GUARD:   w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (!i_tx_busy) begin
                    if (r_byte_idx == IDX_LAST) begin
                        w_state_next = ST_DONE;
                    end else if (w_in_fields && (r_sub == 2'd0)) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_EMIT;
                    end
                end
            end
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Byte offered in EMIT; past the field bytes only the checksum remains.
    always_comb begin
        w_byte = w_csum_byte;
        if (r_byte_idx == IDX_SYNC) begin
            w_byte = SYNC_BYTE;
        end else if (r_byte_idx == IDX_SEQ) begin
            w_byte = r_seq;
        end else if (w_in_fields) begin
            w_byte = r_shift[23:16];
        end
    end

    // r_seq is only written in DONE, so it stays latched for the whole packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq       <= 8'h00;
            r_byte_idx  <= '0;
            r_sub       <= 2'd0;
            r_field_sel <= '0;
            r_shift     <= 24'h000000;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= i_start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_byte_idx <= '0;
                        r_sub      <= 2'd0;
                    end
                end
                ST_LOAD: r_shift <= 24'(i_field_data);
                ST_EMIT: begin
                    if (w_accepted) begin
                        r_byte_idx <= r_byte_idx + CNT_W'(1);
                        if (w_in_fields) begin
                            r_shift <= {r_shift[15:0], 8'h00};
                            r_sub   <= (r_sub == SUB_LAST) ? 2'd0 : r_sub + 2'd1;
                        end
                    end
                end
                ST_WAIT_TX: begin
                    // Select the field before LOAD so its data is stable there.
                    if (w_state_next == ST_LOAD) begin
                        r_field_sel <= (r_byte_idx == IDX_FIELD0) ? '0
                                                                  : r_field_sel + SEL_W'(1);
                    end
                end
                ST_DONE: begin
                    r_seq       <= r_seq + 8'd1;
                    r_field_sel <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef TELEMETRY_CHECKSUM_EN
    logic [7:0] r_csum;

    // The checksum byte itself is also added, which returns the sum to 0x00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 8'h00;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_csum <= 8'h00;
        end else if (w_accepted) begin
            r_csum <= r_csum + w_byte;
        end
    end

    assign w_csum_byte = ~r_csum + 8'd1;
`else
    assign w_csum_byte = 8'h00;
`endif

    telemetry_byte_issuer u_issuer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (w_valid),
        .i_byte        (w_byte),
        .i_tx_busy     (i_tx_busy),
        .i_tx_block    (i_tx_block),
        .o_accepted    (w_accepted),
        .o_tx_data     (o_tx_data),
        .o_new_tx_data (o_new_tx_data)
    );

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_overrun   = r_overrun;
    assign o_seq       = r_seq;
    assign o_field_sel = r_field_sel;

endmodule

// File: tb/tb_telemetry_packetizer.sv
// -----------------------------------------------------------------------------
// tb_telemetry_packetizer
// Directed bench for telemetry_packetizer with a small serial_tx model that
// records every strobed byte with its cycle stamp and can hold tx_busy for a
// programmable number of cycles per byte.
// -----------------------------------------------------------------------------
module tb_telemetry_packetizer;
    import telemetry_pkg::*;

    localparam int NF  = 8;
    localparam int FW  = 20;
    localparam int SW  = 4;
    localparam int LEN = packet_len(NF, CSUM_EN);

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          i_start    = 1'b0;
    logic          i_tx_busy  = 1'b0;
    logic          i_tx_block = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic          o_overrun;
    logic [7:0]    o_seq;
    logic [SW-1:0] o_field_sel;
    logic [FW-1:0] i_field_data;
    logic [7:0]    o_tx_data;
    logic          o_new_tx_data;

    bit            fld_zero = 1'b0;
    int            busy_len = 0;

    int            n_asserts = 0;
    int            n_fail    = 0;

    // Transmitter-model bookkeeping.
    logic [7:0]    rx_q[$];
    int            rx_t[$];
    int            cyc         = 0;
    int            n_done      = 0;
    int            n_viol      = 0;
    int            busy_cnt    = 0;
    bit            prev_strobe = 1'b0;

    logic [7:0]    exp_q[$];

    telemetry_packetizer #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .SEL_W      (SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overrun     (o_overrun),
        .o_seq         (o_seq),
        .o_field_sel   (o_field_sel),
        .i_field_data  (i_field_data),
        .o_tx_data     (o_tx_data),
        .o_new_tx_data (o_new_tx_data),
        .i_tx_busy     (i_tx_busy),
        .i_tx_block    (i_tx_block)
    );

    always #5 clk = ~clk;

    // Sensor read port: field k holds 0x12345 + k, or zero.
    assign i_field_data = fld_zero ? '0 : FW'(20'h12345 + 20'(o_field_sel));

    // serial_tx model, evaluated 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (o_done) n_done = n_done + 1;
        if (o_new_tx_data) begin
            if (i_tx_busy || i_tx_block || prev_strobe) n_viol = n_viol + 1;
            rx_q.push_back(o_tx_data);
            rx_t.push_back(cyc);
            if (busy_len > 0) begin
                i_tx_busy = 1'b1;
                busy_cnt  = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) i_tx_busy = 1'b0;
        end
        prev_strobe = o_new_tx_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!o_done && (k < budget)) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    // Expected packet: A5, seq, fields, then the hand-computed checksum.
    task automatic build_exp(input logic [7:0] seq, input bit zero, input logic [7:0] csum);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int k = 0; k < NF; k++) begin
            if (zero) begin
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
            end else begin
                exp_q.push_back(8'h01);
                exp_q.push_back(8'h23);
                exp_q.push_back(8'h45 + 8'(k));
            end
        end
        if (CSUM_EN) exp_q.push_back(csum);
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_len"}, 32'(rx_q.size() - base), 32'(LEN));
        for (int i = 0; i < LEN; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int base;
        int dbase;
        int nb;
        int t0;
        int k;

        // ---------------- reset values ----------------
        #12;
        check("rst_busy",    32'(o_busy),        32'd0);
        check("rst_done",    32'(o_done),        32'd0);
        check("rst_overrun", 32'(o_overrun),     32'd0);
        check("rst_seq",     32'(o_seq),         32'h00);
        check("rst_sel",     32'(o_field_sel),   32'd0);
        check("rst_txdata",  32'(o_tx_data),     32'h00);
        check("rst_strobe",  32'(o_new_tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- pattern packet, slow transmitter, overrun ----------
        fld_zero = 1'b0;
        busy_len = 10;
        base  = rx_q.size();
        dbase = n_done;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #2;
        check("busy_after_start", 32'(o_busy), 32'd1);
        @(negedge clk);
        i_start = 1'b0;
        wait_bytes("slow_5bytes_timeout", base + 5, 2000);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #2;
        check("overrun_pulse", 32'(o_overrun), 32'd1);
        @(negedge clk);
        i_start = 1'b0;
        @(posedge clk);
        #2;
        check("overrun_one_cycle", 32'(o_overrun), 32'd0);
        wait_done("slow_done_timeout", 6000);
        check("busy_in_done", 32'(o_busy), 32'd1);
        @(posedge clk);
        #2;
        check("done_falls", 32'(o_done), 32'd0);
        check("busy_falls", 32'(o_busy), 32'd0);
        check("slow_done_count", 32'(n_done - dbase), 32'd1);
        check("seq_after_pkt", 32'(o_seq), 32'h01);
        build_exp(8'h00, 1'b0, 8'hF7);
        check_stream("slow", base);

        // ---------------- asynchronous reset mid-packet ----------------
        pulse_start();
        base = rx_q.size();
        wait_bytes("rst_pkt_timeout", base + 3, 2000);
        k = 0;
        while (!o_new_tx_data && (k < 200)) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("rst_strobe_seen", 32'(o_new_tx_data), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_strobe", 32'(o_new_tx_data), 32'd0);
        check("arst_busy",   32'(o_busy),        32'd0);
        check("arst_seq",    32'(o_seq),         32'h00);
        check("arst_sel",    32'(o_field_sel),   32'd0);
        check("arst_txdata", 32'(o_tx_data),     32'h00);
        repeat (15) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- all-zero packet, fast transmitter, timing ----------
        fld_zero = 1'b1;
        busy_len = 0;
        base  = rx_q.size();
        dbase = n_done;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #2;
        t0 = cyc;
        check("no_strobe_at_start_edge", 32'(o_new_tx_data), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        wait_done("zero_done_timeout", 2000);
        @(posedge clk);
        #2;
        check("zero_done_count", 32'(n_done - dbase), 32'd1);
        check("first_strobe_latency", 32'(rx_t[base] - t0), 32'd1);
        check("gap_sync_seq",   32'(rx_t[base + 1] - rx_t[base]),     32'd3);
        check("gap_seq_field",  32'(rx_t[base + 2] - rx_t[base + 1]), 32'd4);
        check("gap_within_fld", 32'(rx_t[base + 3] - rx_t[base + 2]), 32'd3);
        build_exp(8'h00, 1'b1, 8'h5B);
        check_stream("zero", base);

        // ---------------- tx_block window mid-packet ----------------
        fld_zero = 1'b0;
        base = rx_q.size();
        pulse_start();
        wait_bytes("block_pre_timeout", base + 10, 2000);
        @(negedge clk);
        i_tx_block = 1'b1;
        nb = rx_q.size();
        repeat (100) @(negedge clk);
        check("block_no_strobe", 32'(rx_q.size() - nb), 32'd0);
        check("block_busy_held", 32'(o_busy), 32'd1);
        i_tx_block = 1'b0;
        wait_done("block_done_timeout", 2000);
        @(posedge clk);
        #2;
        build_exp(8'h01, 1'b0, 8'hF6);
        check_stream("block", base);

        // ---------------- 257 back-to-back packets, seq wrap ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fld_zero = 1'b1;
        for (int p = 0; p < 257; p++) begin
            base = rx_q.size();
            pulse_start();
            wait_done($sformatf("b2b_done_timeout%0d", p), 500);
            @(posedge clk);
            #2;
            check($sformatf("b2b_seq%0d", p), 32'(rx_q[base + 1]), 32'(p % 256));
        end
        check("seq_after_wrap", 32'(o_seq), 32'h01);

        check("handshake_violations", 32'(n_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
